// File: rtl/ts4231_configurator.sv
// TS4231 configurator: wakes the light-to-digital chip, writes its 14-bit
// configuration word over the E/D pins, reads it back to verify, then puts
// the chip into WATCH mode and releases both pins for the pulse decoder.
module ts4231_configurator #(
  parameter int          PHASE_CYCLES  = 8,
  parameter int          SETTLE_CYCLES = 256,
  parameter logic [13:0] CONFIG_WORD   = 14'h392B,
  parameter int          MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_in,
  input  logic        d_in,
  output logic        e_out,
  output logic        e_oe,
  output logic        d_out,
  output logic        d_oe,
  output logic        configured,
  output logic        failed,
  output logic [13:0] readback,
  output logic [1:0]  retry_cnt
);

  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_WAIT_BUS, S_WAKE, S_CHECK_SLEEP, S_CFG_START, S_WR_DIR, S_WR_BIT,
    S_CFG_STOP, S_RD_DIR, S_RD_BIT, S_VERIFY, S_WATCH_ENTER, S_RETRY,
    S_DONE, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    step_q, step_d;
  logic [3:0]    bit_q, bit_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          rd_q, rd_d;
  logic [13:0]   readback_q, readback_d;
  logic [1:0]    retry_q, retry_d;
  logic          configured_q, configured_d;
  logic          failed_q, failed_d;
  logic          e_meta_q, e_sync_q, d_meta_q, d_sync_q;
  logic          phase_end;

  assign phase_end  = (phase_q == PW'(PHASE_CYCLES - 1));
  assign configured = configured_q;
  assign failed     = failed_q;
  assign readback   = readback_q;
  assign retry_cnt  = retry_q;

  // Two-flop synchronizers for the asynchronous pad inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_meta_q <= 1'b0;
      e_sync_q <= 1'b0;
      d_meta_q <= 1'b0;
      d_sync_q <= 1'b0;
    end else begin
      e_meta_q <= e_in;
      e_sync_q <= e_meta_q;
      d_meta_q <= d_in;
      d_sync_q <= d_meta_q;
    end
  end

  // State register and sequencing counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_WAIT_BUS;
      phase_q      <= '0;
      step_q       <= '0;
      bit_q        <= '0;
      settle_q     <= '0;
      rd_q         <= 1'b0;
      readback_q   <= '0;
      retry_q      <= '0;
      configured_q <= 1'b0;
      failed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      step_q       <= step_d;
      bit_q        <= bit_d;
      settle_q     <= settle_d;
      rd_q         <= rd_d;
      readback_q   <= readback_d;
      retry_q      <= retry_d;
      configured_q <= configured_d;
      failed_q     <= failed_d;
    end
  end

  // Next-state logic: every bus step lasts one phase; step_q walks the sub-steps of a state.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    bit_d        = bit_q;
    settle_d     = '0;
    rd_d         = rd_q;
    readback_d   = readback_q;
    retry_d      = retry_q;
    configured_d = configured_q;
    failed_d     = failed_q;
    case (state_q)
      S_WAIT_BUS: begin
        rd_d = 1'b0;
        if (d_sync_q) begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = S_WAKE;
          else settle_d = settle_q + SW'(1);
        end
      end
      S_WAKE: if (phase_end) state_d = S_CHECK_SLEEP;
      S_CHECK_SLEEP: if (phase_end) state_d = (e_sync_q && d_sync_q) ? S_CFG_START : S_RETRY;
      S_CFG_START: if (phase_end) begin
        if (step_q == 2'd2) state_d = rd_q ? S_RD_DIR : S_WR_DIR;
        else step_d = step_q + 2'd1;
      end
      S_WR_DIR: if (phase_end) begin
        if (step_q == 2'd1) begin
          state_d = S_WR_BIT;
          bit_d   = 4'd13;
        end else step_d = step_q + 2'd1;
      end
      S_WR_BIT: if (phase_end) begin
        if (step_q == 2'd2) begin
          if (bit_q == 4'd0) state_d = S_CFG_STOP;
          else begin
            bit_d  = bit_q - 4'd1;
            step_d = 2'd0;
          end
        end else step_d = step_q + 2'd1;
      end
      S_CFG_STOP: if (phase_end) begin
        if (step_q == 2'd2) begin
          if (rd_q) state_d = S_VERIFY;
          else begin
            state_d = S_CFG_START;
            rd_d    = 1'b1;
          end
        end else step_d = step_q + 2'd1;
      end
      S_RD_DIR: if (phase_end) begin
        state_d = S_RD_BIT;
        bit_d   = 4'd13;
      end
      S_RD_BIT: if (phase_end) begin
        if (step_q == 2'd0) begin
          readback_d[bit_q] = d_sync_q;
          if (bit_q == 4'd0) state_d = S_CFG_STOP;
          else step_d = 2'd1;
        end else begin
          bit_d  = bit_q - 4'd1;
          step_d = 2'd0;
        end
      end
      S_VERIFY: state_d = (readback_q == CONFIG_WORD) ? S_WATCH_ENTER : S_RETRY;
      S_WATCH_ENTER: if (phase_end) begin
        if (step_q == 2'd1) begin
          state_d      = S_DONE;
          configured_d = 1'b1;
        end else step_d = 2'd1;
      end
      S_RETRY: begin
        if (int'(retry_q) < MAX_RETRY) begin
          retry_d = retry_q + 2'd1;
          state_d = S_WAIT_BUS;
        end else begin
          failed_d = 1'b1;
          state_d  = S_FAIL;
        end
      end
      default: state_d = state_q;
    endcase
    if (state_d != state_q) step_d = 2'd0;
    phase_d = (phase_end || (state_d != state_q)) ? '0 : phase_q + PW'(1);
  end

  // Pin drive decode; oe and level come from the same registers so they always change together.
  always_comb begin
    e_oe  = 1'b0;
    e_out = 1'b0;
    d_oe  = 1'b0;
    d_out = 1'b0;
    case (state_q)
      S_WAKE: begin
        e_oe  = 1'b1;
        e_out = 1'b1;
      end
      S_CFG_START: begin
        e_oe  = 1'b1;
        d_oe  = 1'b1;
        e_out = (step_q != 2'd2);
        d_out = (step_q == 2'd0);
      end
      S_WR_DIR: begin
        e_oe  = 1'b1;
        d_oe  = 1'b1;
        e_out = (step_q == 2'd0);
      end
      S_WR_BIT: begin
        e_oe  = 1'b1;
        d_oe  = 1'b1;
        e_out = (step_q == 2'd1);
        d_out = CONFIG_WORD[bit_q];
      end
      S_CFG_STOP: begin
        e_oe  = 1'b1;
        d_oe  = 1'b1;
        e_out = (step_q != 2'd0);
        d_out = (step_q == 2'd2);
      end
      S_RD_DIR, S_VERIFY: begin
        e_oe  = 1'b1;
        d_oe  = 1'b1;
        e_out = 1'b1;
        d_out = 1'b1;
      end
      S_RD_BIT: begin
        e_oe  = 1'b1;
        e_out = (step_q == 2'd1);
      end
      S_WATCH_ENTER: begin
        e_oe  = 1'b1;
        d_oe  = 1'b1;
        d_out = (step_q == 2'd0);
      end
      default: begin
        e_oe = 1'b0;
        d_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ts4231_configurator.sv
// Bench for ts4231_configurator: a behavioural TS4231 model on pulled-up E/D
// lines plus directed scenarios with hand-computed timing.
module tb_ts4231_configurator;

  localparam int PHASE   = 8;
  localparam int SETTLE  = 256;
  localparam logic [13:0] WORD = 14'h392B;
  // wake, check, start, wr dir, 14x3 bits, stop, start, rd dir, 14 low + 13 high, stop, watch; plus 1 verify cycle
  localparam int NOMINAL = (1 + 1 + 3 + 2 + 14*3 + 3 + 3 + 1 + 27 + 3 + 2) * PHASE + 1;
  localparam int WAKE_LAT = SETTLE + 2;

  logic clk = 1'b0;
  logic reset;
  logic e_in, d_in;
  logic e_out, e_oe, d_out, d_oe, configured, failed;
  logic [13:0] readback;
  logic [1:0]  retry_cnt;

  typedef enum logic [1:0] {CH_SLEEP, CH_CFG, CH_WATCH} chip_mode_t;
  chip_mode_t  chipMode;
  logic        chipRst, forceZero, light, benchDLow;
  logic        chipEOe, chipE, chipDOe, chipD;
  logic        prevE, prevD, dirRead;
  logic [13:0] chipReg, rdWord;
  int          cfgCnt, rdIdx;

  int assertCount = 0;
  int failCount   = 0;
  int bothCount   = 0;
  int cfgWhileZero = 0;
  int n, w, oeSeen, eChanges;
  logic lastE;

  ts4231_configurator dut (
    .clk(clk), .reset(reset), .e_in(e_in), .d_in(d_in),
    .e_out(e_out), .e_oe(e_oe), .d_out(d_out), .d_oe(d_oe),
    .configured(configured), .failed(failed),
    .readback(readback), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  assign chipEOe = (chipMode == CH_WATCH);
  assign chipE   = light;
  assign rdWord  = forceZero ? 14'h0000 : chipReg;
  assign e_in = e_oe ? e_out : (chipEOe ? chipE : 1'b1);
  assign d_in = d_oe ? d_out : (benchDLow ? 1'b0 : (chipDOe ? chipD : 1'b1));

  // Chip model: decodes bus events between successive samples taken away from the FPGA edge.
  always @(negedge clk) begin
    if (chipRst) begin
      chipMode <= CH_SLEEP;
      chipDOe  <= 1'b0;
      chipD    <= 1'b0;
      chipReg  <= 14'h0000;
      cfgCnt   <= 0;
      rdIdx    <= 0;
      dirRead  <= 1'b0;
      prevE    <= 1'b1;
      prevD    <= 1'b1;
    end else begin
      prevE <= e_in;
      prevD <= d_in;
      if (prevE && e_in && prevD && !d_in) begin
        chipMode <= CH_CFG;
        cfgCnt   <= 0;
        rdIdx    <= 0;
        dirRead  <= 1'b0;
      end else if (chipMode == CH_CFG && prevE && e_in && !prevD && d_in) begin
        chipMode <= CH_SLEEP;
        chipDOe  <= 1'b0;
      end else if (chipMode == CH_SLEEP && !prevE && !e_in && prevD && !d_in) begin
        chipMode <= CH_WATCH;
      end else if (chipMode == CH_CFG && !prevE && e_in) begin
        if (cfgCnt == 0) begin
          dirRead <= d_in;
          cfgCnt  <= 1;
        end else if (!dirRead && cfgCnt <= 14) begin
          chipReg <= {chipReg[12:0], d_in};
          cfgCnt  <= cfgCnt + 1;
        end
      end else if (chipMode == CH_CFG && prevE && !e_in && dirRead && rdIdx < 14) begin
        chipDOe <= 1'b1;
        chipD   <= rdWord[13 - rdIdx];
        rdIdx   <= rdIdx + 1;
      end
    end
  end

  // Status monitors sampled on the inactive edge.
  always @(negedge clk) begin
    if (!reset && configured && failed) bothCount <= bothCount + 1;
    if (!reset && forceZero && configured) cfgWhileZero <= cfgWhileZero + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rstVal, input logic chipRstVal, input int cycles);
    reset   = rstVal;
    chipRst = chipRstVal;
    waitCycles(cycles);
  endtask

  // Waits for e_oe (0), configured (1) or failed (2); an expired bound is a failed comparison.
  task automatic waitSig(input int sel, input int limit, output int cycles);
    logic hit;
    cycles = 0;
    hit = 1'b0;
    while (!hit && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
      case (sel)
        0: hit = e_oe;
        1: hit = configured;
        default: hit = failed;
      endcase
    end
    if (!hit) checkOutput($sformatf("timeout_sel%0d", sel), 32'd0, 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pins"}, {28'd0, e_oe, d_oe, e_out, d_out}, 32'd0);
    checkOutput({tag, "_configured"}, {31'd0, configured}, 32'd0);
    checkOutput({tag, "_failed"}, {31'd0, failed}, 32'd0);
    checkOutput({tag, "_readback"}, {18'd0, readback}, 32'd0);
    checkOutput({tag, "_retry"}, {30'd0, retry_cnt}, 32'd0);
  endtask

  initial begin
    forceZero = 1'b0;
    light     = 1'b0;
    benchDLow = 1'b0;
    applyStimulus(1'b1, 1'b1, 3);
    checkResetState("reset");

    // Bus settle interrupted by D low 100 cycles into WAIT_BUS
    applyStimulus(1'b0, 1'b0, 100);
    benchDLow = 1'b1;
    waitCycles(30);
    checkOutput("no_wake_while_d_low", {31'd0, e_oe}, 32'd0);
    benchDLow = 1'b0;
    waitSig(0, 600, n);
    checkOutput("wake_after_d_high", n, WAKE_LAT);
    checkOutput("wake_levels", {29'd0, e_out, d_oe, d_out}, 32'b100);
    w = 1;
    while (w < 50) begin
      waitCycles(1);
      if (e_oe && e_out) w++;
      else break;
    end
    checkOutput("wake_width", w, PHASE);

    // Full nominal sequence into WATCH
    waitSig(1, 2000, n);
    checkOutput("nominal_duration", w + n, NOMINAL);
    checkOutput("configured", {31'd0, configured}, 32'd1);
    checkOutput("not_failed", {31'd0, failed}, 32'd0);
    checkOutput("readback", {18'd0, readback}, {18'd0, WORD});
    checkOutput("chip_register", {18'd0, chipReg}, {18'd0, WORD});
    checkOutput("retry_zero", {30'd0, retry_cnt}, 32'd0);
    checkOutput("released_done", {30'd0, e_oe, d_oe}, 32'd0);
    checkOutput("chip_in_watch", {31'd0, chipMode == CH_WATCH}, 32'd1);

    // Light pulses while configured: only the chip drives E
    oeSeen = 0;
    eChanges = 0;
    lastE = e_in;
    for (int i = 0; i < 200; i++) begin
      if (i % 7 == 0) light = ~light;
      waitCycles(1);
      if (e_oe || d_oe) oeSeen++;
      if (e_in !== lastE) eChanges++;
      lastE = e_in;
    end
    light = 1'b0;
    checkOutput("released_under_light", oeSeen, 0);
    checkOutput("chip_drives_e", {31'd0, eChanges > 20}, 32'd1);
    checkOutput("configured_holds", {31'd0, configured}, 32'd1);

    // Reset during bit 7 of the write, then a clean re-run
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 0);
    waitSig(0, 600, n);
    checkOutput("wake_after_reset", n, WAKE_LAT);
    waitCycles((1 + 1 + 3 + 2 + 6*3) * PHASE + 4);
    checkOutput("bit7_driving", {30'd0, e_oe, d_oe}, 32'b11);
    checkOutput("bit7_d_level", {31'd0, d_out}, {31'd0, WORD[7]});
    reset = 1'b1;
    waitCycles(1);
    checkResetState("mid_reset");
    reset = 1'b0;
    waitSig(1, 2000, n);
    checkOutput("rerun_configured", {31'd0, configured}, 32'd1);
    checkOutput("rerun_chip_register", {18'd0, chipReg}, {18'd0, WORD});
    checkOutput("rerun_readback", {18'd0, readback}, {18'd0, WORD});

    // Chip answers all-zero on read: retries exhaust and failed sticks
    applyStimulus(1'b1, 1'b1, 3);
    forceZero = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    waitSig(2, 8000, n);
    checkOutput("failed_set", {31'd0, failed}, 32'd1);
    checkOutput("failed_retry", {30'd0, retry_cnt}, 32'd3);
    checkOutput("failed_not_configured", {31'd0, configured}, 32'd0);
    checkOutput("failed_readback", {18'd0, readback}, 32'd0);
    waitCycles(50);
    checkOutput("failed_released", {30'd0, e_oe, d_oe}, 32'd0);
    checkOutput("failed_sticky", {31'd0, failed}, 32'd1);
    checkOutput("no_configured_on_bad_read", cfgWhileZero, 0);
    checkOutput("never_both", bothCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
